// File: rtl/adder_pipe.sv
// Pipelined carry-segmented adder/subtractor.
// One register stage per SEG-bit carry segment, valid/ready handshake.
module adder_pipe #(
  parameter int WA  = 8,
  parameter int WB  = 5,
  parameter int SEG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] sum,
  output logic          cout
);

  localparam int NSTG = (WA + SEG - 1) / SEG;

  logic                     adv;
  logic [WA-1:0]            bx;
  logic [WA-1:0]            beff;
  logic [NSTG-1:0][WA-1:0]  aq;
  logic [NSTG-1:0][WA-1:0]  bq;
  logic [NSTG-1:0][WA-1:0]  sq;
  logic [NSTG-1:0]          cq;
  logic [NSTG-1:0]          vq;
  logic                     unused_skew;

  assign bx   = WA'(b);
  assign beff = sub ? ~bx : bx;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vq[NSTG-1];
  assign sum       = sq[NSTG-1];
  assign cout      = cq[NSTG-1];

  // Last stage has no later segment to feed, so its skew copy is dead.
  assign unused_skew = ^{aq[NSTG-1], bq[NSTG-1]};

  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int LO = k * SEG;
    localparam int HI = ((k + 1) * SEG > WA) ? WA : (k + 1) * SEG;
    localparam int W  = HI - LO;

    logic [WA-1:0] ai;
    logic [WA-1:0] bi;
    logic [WA-1:0] si;
    logic [WA-1:0] sn;
    logic          ci;
    logic          vi;
    logic [W:0]    sg;

    if (k == 0) begin : g_src
      assign ai = a;
      assign bi = beff;
      assign si = '0;
      assign ci = sub;
      assign vi = in_valid & adv;
    end else begin : g_skw
      assign ai = aq[k-1];
      assign bi = bq[k-1];
      assign si = sq[k-1];
      assign ci = cq[k-1];
      assign vi = vq[k-1];
    end

    assign sg = {1'b0, ai[HI-1:LO]}
              + {1'b0, bi[HI-1:LO]}
              + (W+1)'(ci);

    always_comb begin
      sn        = si;
      sn[HI-1:LO] = sg[W-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vq[k] <= 1'b0;
        cq[k] <= 1'b0;
        aq[k] <= '0;
        bq[k] <= '0;
        sq[k] <= '0;
      end else if (adv) begin
        vq[k] <= vi;
        if (vi) begin
          cq[k] <= sg[W];
          aq[k] <= ai;
          bq[k] <= bi;
          sq[k] <= sn;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: default, wide-segment and
// single-stage configurations against an arithmetic reference model.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [4:0] b = '0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;

  logic        iv16 = 1'b0;
  logic        ir16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        sub16 = 1'b0;
  logic        ov16;
  logic        or16 = 1'b0;
  logic [15:0] sum16;
  logic        co16;

  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       sub8 = 1'b0;
  logic       ov8;
  logic       or8 = 1'b0;
  logic [7:0] sum8;
  logic       co8;

  int checks = 0;
  int errors = 0;
  logic [8:0]  expq[$];
  logic [16:0] expq16[$];

  adder_pipe #(.WA(8), .WB(5), .SEG(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  adder_pipe #(.WA(16), .WB(16), .SEG(5)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .cout(co16)
  );

  adder_pipe #(.WA(8), .WB(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .cout(co8)
  );

  function automatic logic [8:0] model8(logic [7:0] x, logic [4:0] y, logic s);
    int unsigned xv = x;
    int unsigned yv = y;
    if (s) return {(xv >= yv), 8'(xv - yv)};
    return 9'(xv + yv);
  endfunction

  function automatic logic [16:0] model16(logic [15:0] x, logic [15:0] y, logic s);
    int unsigned xv = x;
    int unsigned yv = y;
    if (s) return {(xv >= yv), 16'(xv - yv)};
    return 17'(xv + yv);
  endfunction

  task automatic drive(logic r, logic iv, logic [7:0] ia, logic [4:0] ib,
                       logic is, logic ordy);
    @(negedge clk);
    rst = r;
    in_valid = iv;
    a = ia;
    b = ib;
    sub = is;
    out_ready = ordy;
    #1;
  endtask

  task automatic run_one(logic [7:0] ia, logic [4:0] ib, logic is,
                         output int lat, output logic [7:0] s,
                         output logic c);
    lat = -1;
    s = '0;
    c = 1'b0;
    drive(1'b0, 1'b1, ia, ib, is, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid && lat < 0) begin
        lat = i;
        s = sum;
        c = cout;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, cout, sum} !== 10'd0) begin
      errors++;
      $display("FAIL reset_out got v=%0b c=%0b s=%h want 0 0 00",
               out_valid, cout, sum);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", in_ready);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_add_wrap;
    int lat;
    logic [7:0] s;
    logic c;
    run_one(8'hFF, 5'h1F, 1'b0, lat, s, c);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL add_latency got %0d want 2", lat);
    end
    checks++;
    if ({c, s} !== 9'h11E) begin
      errors++;
      $display("FAIL add_wrap got %0b/%h want 1/1e", c, s);
    end
  endtask

  task automatic test_sub;
    int lat;
    logic [7:0] s;
    logic c;
    run_one(8'd5, 5'd7, 1'b1, lat, s, c);
    checks++;
    if (lat != 2 || {c, s} !== {1'b0, 8'hFE}) begin
      errors++;
      $display("FAIL sub_borrow got lat=%0d %0b/%h want 2 0/fe", lat, c, s);
    end
    run_one(8'd200, 5'd31, 1'b1, lat, s, c);
    checks++;
    if (lat != 2 || {c, s} !== {1'b1, 8'd169}) begin
      errors++;
      $display("FAIL sub_noborrow got lat=%0d %0b/%0d want 2 1/169", lat, c, s);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta[16];
    logic [4:0] tb[16];
    logic       ts[16];
    int nsent = 0;
    int nrx = 0;
    int first = -1;
    int last = -1;
    logic [8:0] e;
    for (int i = 0; i < 16; i++) begin
      ta[i] = 8'($urandom);
      tb[i] = 5'($urandom);
      ts[i] = 1'($urandom_range(0, 1));
    end
    expq.delete();
    for (int cyc = 0; cyc < 28; cyc++) begin
      if (nsent < 16)
        drive(1'b0, 1'b1, ta[nsent], tb[nsent], ts[nsent], 1'b1);
      else
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got %0b/%h want none", cout, sum);
        end else begin
          e = expq.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL b2b_result got %0b/%h want %0b/%h",
                     cout, sum, e[8], e[7:0]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        nrx++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model8(a, b, sub));
        nsent++;
      end
    end
    checks++;
    if (nrx != 16 || first != 2 || last != 17) begin
      errors++;
      $display("FAIL b2b_rate got n=%0d first=%0d last=%0d want 16 2 17",
               nrx, first, last);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] ta[4];
    logic [4:0] tb[4];
    logic       ts[4];
    int idx = 0;
    int nrx = 0;
    bit have = 0;
    logic [8:0] snap = '0;
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      ta[i] = 8'($urandom);
      tb[i] = 5'($urandom);
      ts[i] = 1'($urandom_range(0, 1));
    end
    expq.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive(1'b0, idx < 3, ta[idx], tb[idx], ts[idx], cyc >= 5);
      if (out_valid && !out_ready) begin
        if (!have) begin
          snap = {cout, sum};
          have = 1;
        end else begin
          checks++;
          if ({cout, sum} !== snap) begin
            errors++;
            $display("FAIL bp_hold got %0b/%h want %0b/%h",
                     cout, sum, snap[8], snap[7:0]);
          end
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready got %0b want 0", in_ready);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (idx != 2 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_fill got acc=%0d v=%0b want 2 1", idx, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got %0b/%h want none", cout, sum);
        end else begin
          e = expq.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL bp_result got %0b/%h want %0b/%h",
                     cout, sum, e[8], e[7:0]);
          end
        end
        nrx++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model8(a, b, sub));
        idx++;
      end
    end
    checks++;
    if (nrx != 3 || expq.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d left=%0d want 3 0", nrx, expq.size());
    end
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    drive(1'b0, 1'b1, 8'hA5, 5'd3, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'h3C, 5'd9, 1'b1, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, cout, sum} !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_out got v=%0b c=%0b s=%h want 0 0 00",
               out_valid, cout, sum);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rstmid_stale got %0d valid cycles want 0", stale);
    end
  endtask

  task automatic test_wide_seg;
    int lat = -1;
    int nsent = 0;
    int nrx = 0;
    logic [16:0] got = '0;
    logic [16:0] e;
    @(negedge clk);
    iv16 = 1'b1;
    a16 = 16'hFFFF;
    b16 = 16'h0001;
    sub16 = 1'b0;
    or16 = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      iv16 = 1'b0;
      #1;
      if (ov16 && lat < 0) begin
        lat = i;
        got = {co16, sum16};
      end
    end
    checks++;
    if (lat != 4 || got !== 17'h10000) begin
      errors++;
      $display("FAIL wide_carry got lat=%0d %0b/%h want 4 1/0000",
               lat, got[16], got[15:0]);
    end
    expq16.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      iv16 = (nsent < 8);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      sub16 = 1'($urandom_range(0, 1));
      or16 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov16 && or16) begin
        checks++;
        if (expq16.size() == 0) begin
          errors++;
          $display("FAIL wide_extra got %0b/%h want none", co16, sum16);
        end else begin
          e = expq16.pop_front();
          if ({co16, sum16} !== e) begin
            errors++;
            $display("FAIL wide_result got %0b/%h want %0b/%h",
                     co16, sum16, e[16], e[15:0]);
          end
        end
        nrx++;
      end
      if (iv16 && ir16) begin
        expq16.push_back(model16(a16, b16, sub16));
        nsent++;
      end
    end
    checks++;
    if (nrx != 8) begin
      errors++;
      $display("FAIL wide_count got %0d want 8", nrx);
    end
  endtask

  task automatic test_single_stage;
    logic [7:0] xa[2];
    logic [7:0] xb[2];
    logic       xs[2];
    logic [8:0] want[2];
    int lat;
    logic [8:0] got;
    xa[0] = 8'h80; xb[0] = 8'h80; xs[0] = 1'b0; want[0] = 9'h100;
    xa[1] = 8'h10; xb[1] = 8'h20; xs[1] = 1'b1; want[1] = 9'h0F0;
    for (int t = 0; t < 2; t++) begin
      lat = -1;
      got = '0;
      @(negedge clk);
      iv8 = 1'b1;
      a8 = xa[t];
      b8 = xb[t];
      sub8 = xs[t];
      or8 = 1'b1;
      #1;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        iv8 = 1'b0;
        #1;
        if (ov8 && lat < 0) begin
          lat = i;
          got = {co8, sum8};
        end
      end
      checks++;
      if (lat != 1 || got !== want[t]) begin
        errors++;
        $display("FAIL single_stage%0d got lat=%0d %0b/%h want 1 %0b/%h",
                 t, lat, got[8], got[7:0], want[t][8], want[t][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide_seg();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
